// File: rtl/alu_seq.sv
// alu_seq: handshaked integer ALU with one-cycle ADD/SUB and an iterative
// shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// Optional feature macro: ALU_MULH_EN (opcode 11 returns the high half of
// the unsigned product; otherwise opcode 11 is reported as illegal).
module alu_seq #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal,
  output logic             busy
);

  localparam int unsigned N_STEPS = WIDTH / MUL_STEP;
  localparam int unsigned CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
`ifdef ALU_MULH_EN
  localparam int unsigned AW      = 2 * WIDTH;
`else
  // Only the low half is ever returned, so the accumulator can be narrow.
  localparam int unsigned AW      = WIDTH + MUL_STEP;
`endif

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_MULH = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      mcand;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               is_mul_c;
`ifdef ALU_MULH_EN
  logic               want_high;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Opcodes that go through the multiplier engine.
  always_comb begin
    is_mul_c = (opcode == OP_MUL);
`ifdef ALU_MULH_EN
    if (opcode == OP_MULH) is_mul_c = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = is_mul_c ? MUL_BUSY : DONE;
      MUL_BUSY: if (cnt == '0) state_nxt = DONE;
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // One multiplier step: add the shifted multiplicand for each set bit.
  always_comb begin
    acc_step = acc;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (mplier[i]) acc_step = acc_step + (mcand << i);
    end
  end

  // Operand capture, multiplier iteration and result holding.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_MULH_EN
      want_high <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            illegal <= 1'b0;
            if (is_mul_c) begin
              mcand  <= AW'(a);
              mplier <= b;
              acc    <= '0;
              cnt    <= CNT_W'(N_STEPS - 1);
`ifdef ALU_MULH_EN
              want_high <= (opcode == OP_MULH);
`endif
            end else begin
              out_valid <= 1'b1;
              case (opcode)
                OP_ADD:  result <= a + b;
                OP_SUB:  result <= a - b;
                default: begin
                  result  <= '0;
                  illegal <= 1'b1;
                end
              endcase
            end
          end
        end
        MUL_BUSY: begin
          acc    <= acc_step;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          if (cnt == '0) begin
            out_valid <= 1'b1;
`ifdef ALU_MULH_EN
            result <= want_high ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
`else
            result <= acc_step[WIDTH-1:0];
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: scoreboard queue of expected results,
// filled when an operation is driven and drained at each output handoff.
module tb_alu_seq;

  localparam int unsigned W = 32;
`ifdef ALU_MULH_EN
  localparam int OP11_LAT = 33;
`else
  localparam int OP11_LAT = 1;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         ill;
  } exp_t;

  logic         clock;
  logic         reset_n;
  logic         in_valid, in_valid4;
  logic         out_ready, out_ready4;
  logic [1:0]   opcode;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, illegal, busy;
  logic [W-1:0] result;
  logic         in_ready4, out_valid4, illegal4, busy4;
  logic [W-1:0] result4;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  alu_seq #(.WIDTH(W), .MUL_STEP(1)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal), .busy(busy)
  );

  alu_seq #(.WIDTH(W), .MUL_STEP(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .illegal(illegal4), .busy(busy4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference behaviour of one operation.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    e.ill = 1'b0;
    case (op)
      2'b00:   e.res = x + y;
      2'b01:   e.res = x - y;
      2'b10:   e.res = p[W-1:0];
      default: begin
`ifdef ALU_MULH_EN
        e.res = p[2*W-1:W];
`else
        e.res = '0;
        e.ill = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  function automatic int lat_of(input logic [1:0] op);
    if (op == 2'b10) return 33;
    if (op == 2'b11) return OP11_LAT;
    return 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present an operation, wait (bounded) for acceptance; returns #1 after the accept edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int waited = 0;
    @(negedge clock);
    in_valid = 1'b1;
    opcode   = op;
    a        = x;
    b        = y;
    while (!in_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    check("accept", 64'(in_ready), 64'd1);
    sb.push_back(model(op, x, y));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    a        = ~x;
    b        = ~y;
  endtask

  // Wait for the result, optionally stall, then hand off and compare with the scoreboard.
  task automatic recv(input string tag, input int stall, input int exp_lat, input bit poke);
    int   lat = 1;
    int   bad_busy = 0;
    int   bad_hold = 0;
    exp_t e;
    while (!out_valid && lat < 200) begin
      if (in_ready || !busy) bad_busy++;
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(bad_busy), 64'd0);
    e = sb.pop_front();
    check({tag, "_result"}, 64'(result), 64'(e.res));
    check({tag, "_illegal"}, 64'(illegal), 64'(e.ill));
    if (poke) begin
      in_valid = 1'b1;
      opcode   = 2'b01;
      a        = 32'd9;
      b        = 32'd3;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clock);
      #1;
      if (result !== e.res || !out_valid || in_ready || illegal !== e.ill) bad_hold++;
    end
    check({tag, "_hold"}, 64'(bad_hold), 64'd0);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int quiet;
    int lat;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    exp_t e;

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_valid4  = 1'b0;
    out_ready  = 1'b0;
    out_ready4 = 1'b0;
    opcode     = 2'b00;
    a          = '0;
    b          = '0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Wrap-around ADD/SUB
    send(2'b00, 32'hFFFF_FFFF, 32'h2);
    recv("add_wrap", 0, 1, 1'b0);
    send(2'b01, 32'h0, 32'h1);
    recv("sub_wrap", 0, 1, 1'b0);

    // Iterative multiply
    send(2'b10, 32'h0001_0000, 32'h0001_0003);
    recv("mul", 0, 33, 1'b0);
    send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    recv("mul_ones", 0, 33, 1'b0);

    // Opcode 11: MULH or illegal depending on build
    send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    recv("op11", 0, OP11_LAT, 1'b0);
    send(2'b00, 32'd10, 32'd20);
    recv("after_op11", 0, 1, 1'b0);

    // Back-pressure with a competing request held during the stall
    send(2'b00, 32'd5, 32'd7);
    recv("bp", 10, 1, 1'b1);
    sb.push_back(model(2'b01, 32'd9, 32'd3));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    recv("bp_second", 0, 1, 1'b0);

    // Reset in the middle of a multiply
    send(2'b10, 32'h1234_5678, 32'h0000_0FFF);
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_result", 64'(result), 64'd0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) quiet++;
    end
    check("midrst_no_result", 64'(quiet), 64'd0);
    send(2'b00, 32'd1, 32'd1);
    recv("post_rst_add", 0, 1, 1'b0);

    // Mixed random operations
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      send(rop, ra, rb);
      recv("rand", i % 3, lat_of(rop), 1'b0);
    end

    // Four bits per cycle multiplier
    @(negedge clock);
    check("mul4_ready", 64'(in_ready4), 64'd1);
    opcode    = 2'b10;
    a         = 32'h1234_5678;
    b         = 32'h9ABC_DEF0;
    in_valid4 = 1'b1;
    sb.push_back(model(2'b10, 32'h1234_5678, 32'h9ABC_DEF0));
    @(posedge clock);
    #1;
    in_valid4 = 1'b0;
    a         = '0;
    lat       = 1;
    while (!out_valid4 && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    e = sb.pop_front();
    check("mul4_lat", 64'(lat), 64'd9);
    check("mul4_result", 64'(result4), 64'(e.res));
    check("mul4_illegal", 64'(illegal4), 64'(e.ill));
    out_ready4 = 1'b1;
    @(posedge clock);
    #1;
    out_ready4 = 1'b0;
    check("mul4_idle", 64'(busy4), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
